// File: rtl/reserved_parking_exit_pkg.sv
// Shared definitions for the reserved-parking exit/entry controllers.
// Holds the slot-count define, result codes, FSM state encoding and the
// flat-number range check so every consumer decodes the same values.
`ifndef PARKING_SLOTS
`define PARKING_SLOTS 8
`endif

package reserved_parking_exit_pkg;

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_INVALID = 3'd1;
    localparam logic [2:0] ERR_AUTH    = 3'd2;
    localparam logic [2:0] ERR_EMPTY   = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_OPEN      = 3'd2,
        ST_WAIT_PASS = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_REJECT    = 3'd5
    } state_e;

    // Flats are numbered 1..n+1; anything else addresses no slot.
    function automatic bit flat_ok(input int flat, input int n);
        return (flat >= 1) && (flat <= n + 1);
    endfunction

endpackage

// File: rtl/reserved_parking_exit_if.sv
// Resident/entry-side signal bundle for the reserved-parking exit block.
// master: requester side (drives requests, sensor, entry set).
// slave : the exit controller (drives status, gate, result, bitmap view).
interface reserved_parking_exit_if #(
    parameter int N = `PARKING_SLOTS
);
    localparam int FLAT_W = $clog2(N) + 1;

    logic              exit_req;
    logic              pwd_flag;
    logic [FLAT_W-1:0] flat_number;
    logic              vehicle_passed;
    logic              entry_set;
    logic [FLAT_W-1:0] entry_flat;
    logic              busy;
    logic              gate_open;
    logic              exit_done;
    logic [2:0]        err_code;
    logic [N:0]        occupancy;
    logic [FLAT_W-1:0] free_count;

    modport master (
        output exit_req, pwd_flag, flat_number, vehicle_passed, entry_set, entry_flat,
        input  busy, gate_open, exit_done, err_code, occupancy, free_count
    );

    modport slave (
        input  exit_req, pwd_flag, flat_number, vehicle_passed, entry_set, entry_flat,
        output busy, gate_open, exit_done, err_code, occupancy, free_count
    );
endinterface

// File: rtl/reserved_parking_exit_bitmap.sv
// Reserved-slot occupancy register.
// Ports: clk/rst_n; set_en_i/set_flat_i (entry side), clr_en_i/clr_flat_i
// (exit release); occupancy_o (bit k = flat k+1), free_count_o (zero count).
// Out-of-range flats are ignored; a set and clear on the same bit leave it set.
module reserved_slot_bitmap
    import reserved_parking_exit_pkg::*;
#(
    parameter int N = `PARKING_SLOTS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          set_en_i,
    input  logic [$clog2(N):0]            set_flat_i,
    input  logic                          clr_en_i,
    input  logic [$clog2(N):0]            clr_flat_i,
    output logic [N:0]                    occupancy_o,
    output logic [$clog2(N):0]            free_count_o
);
    localparam int FLAT_W = $clog2(N) + 1;
    localparam int NS     = N + 1;

    logic [NS-1:0]     occ_q, occ_d;
    logic [FLAT_W-1:0] free_q, free_d;
    logic [FLAT_W:0]   set_idx, clr_idx;
    logic              set_ok, clr_ok;

    // One extra bit so flat 0 cannot wrap into a valid index.
    assign set_idx = {1'b0, set_flat_i} - (FLAT_W+1)'(1);
    assign clr_idx = {1'b0, clr_flat_i} - (FLAT_W+1)'(1);
    assign set_ok  = set_en_i && flat_ok(int'(set_flat_i), N);
    assign clr_ok  = clr_en_i && flat_ok(int'(clr_flat_i), N);

    always_comb begin
        occ_d  = occ_q;
        free_d = '0;
        for (int k = 0; k < NS; k++) begin
            if (clr_ok && clr_idx == (FLAT_W+1)'(k)) occ_d[k] = 1'b0;
            // Applied after the clear so an entry arriving on release wins.
            if (set_ok && set_idx == (FLAT_W+1)'(k)) occ_d[k] = 1'b1;
        end
        for (int k = 0; k < NS; k++) begin
            if (!occ_d[k]) free_d = free_d + FLAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= '0;
            free_q <= FLAT_W'(NS);
        end else begin
            occ_q  <= occ_d;
            free_q <= free_d;
        end
    end

    assign occupancy_o  = occ_q;
    assign free_count_o = free_q;
endmodule

// File: rtl/reserved_parking_exit.sv
// Exit-side controller for reserved parking: validates a resident's exit
// request, opens the gate, waits for the vehicle sensor (with timeout) and
// releases the flat's slot in the shared occupancy bitmap.
// Ports: clk, rst_n (async, active-low); bus (slave modport) carrying the
// request/sensor/entry inputs and busy/gate/result/occupancy outputs.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | waiting for exit_req; latches flat and password flag
// ST_CHECK     | range, password and occupancy checks (one cycle)
// ST_OPEN      | gate driven, timer cleared
// ST_WAIT_PASS | gate driven, timer counting, waiting for vehicle_passed
// ST_RELEASE   | clear slot, report OK
// ST_REJECT    | report the latched failure code, gate stays closed
module reserved_parking_exit
    import reserved_parking_exit_pkg::*;
#(
    parameter int N           = `PARKING_SLOTS,
    parameter int GATE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    reserved_parking_exit_if.slave bus
);
    localparam int FLAT_W = $clog2(N) + 1;
    localparam int NS     = N + 1;
    localparam int TW     = $clog2(GATE_CYCLES);

    state_e            state_q, state_d;
    logic [FLAT_W-1:0] flat_q, flat_d;
    logic              pwd_q, pwd_d;
    logic [2:0]        rej_q, rej_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              exit_done_q, exit_done_d;
    logic [2:0]        err_q, err_d;
    logic [NS-1:0]     occ;
    logic [FLAT_W-1:0] free_cnt;
    logic [FLAT_W:0]   flat_idx;
    logic              flat_valid;
    logic              slot_occ;

    assign flat_idx   = {1'b0, flat_q} - (FLAT_W+1)'(1);
    assign flat_valid = flat_ok(int'(flat_q), N);

    always_comb begin
        slot_occ = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (flat_valid && flat_idx == (FLAT_W+1)'(k)) slot_occ = occ[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            flat_q  <= '0;
            pwd_q   <= 1'b0;
            rej_q   <= ERR_OK;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            flat_q  <= flat_d;
            pwd_q   <= pwd_d;
            rej_q   <= rej_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        flat_d  = flat_q;
        pwd_d   = pwd_q;
        rej_d   = rej_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.exit_req) begin
                    flat_d  = bus.flat_number;
                    pwd_d   = bus.pwd_flag;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!flat_valid) begin
                    rej_d   = ERR_INVALID;
                    state_d = ST_REJECT;
                end else if (!pwd_q) begin
                    rej_d   = ERR_AUTH;
                    state_d = ST_REJECT;
                end else if (!slot_occ) begin
                    rej_d   = ERR_EMPTY;
                    state_d = ST_REJECT;
                end else begin
                    state_d = ST_OPEN;
                end
            end
            ST_OPEN: begin
                timer_d = '0;
                state_d = ST_WAIT_PASS;
            end
            ST_WAIT_PASS: begin
                timer_d = timer_q + TW'(1);
                // Pass is checked first so it wins on the timeout cycle.
                if (bus.vehicle_passed)                    state_d = ST_RELEASE;
                else if (timer_d == TW'(GATE_CYCLES - 1))  state_d = ST_IDLE;
            end
            ST_RELEASE: state_d = ST_IDLE;
            ST_REJECT:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Result is registered so it appears together with the bitmap update.
    always_comb begin
        exit_done_d = 1'b0;
        err_d       = err_q;
        case (state_q)
            ST_REJECT: begin
                exit_done_d = 1'b1;
                err_d       = rej_q;
            end
            ST_RELEASE: begin
                exit_done_d = 1'b1;
                err_d       = ERR_OK;
            end
            ST_WAIT_PASS: begin
                if (!bus.vehicle_passed && timer_d == TW'(GATE_CYCLES - 1)) begin
                    exit_done_d = 1'b1;
                    err_d       = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exit_done_q <= 1'b0;
            err_q       <= ERR_OK;
        end else begin
            exit_done_q <= exit_done_d;
            err_q       <= err_d;
        end
    end

    reserved_slot_bitmap #(.N(N)) u_bitmap (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_en_i     (bus.entry_set),
        .set_flat_i   (bus.entry_flat),
        .clr_en_i     (state_q == ST_RELEASE),
        .clr_flat_i   (flat_q),
        .occupancy_o  (occ),
        .free_count_o (free_cnt)
    );

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.gate_open  = (state_q == ST_OPEN) || (state_q == ST_WAIT_PASS);
    assign bus.exit_done  = exit_done_q;
    assign bus.err_code   = err_q;
    assign bus.occupancy  = occ;
    assign bus.free_count = free_cnt;
endmodule

// File: tb/tb_reserved_parking_exit.sv
`ifndef PARKING_SLOTS
`define PARKING_SLOTS 8
`endif

module tb_reserved_parking_exit;
    import reserved_parking_exit_pkg::*;

    localparam int N  = `PARKING_SLOTS;
    localparam int NS = N + 1;
    localparam int FW = $clog2(N) + 1;

    typedef struct packed {
        logic [2:0]    err;
        logic [NS-1:0] occ;
        logic [FW-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   issued = 0;
    int   done_seen = 0;
    logic [NS-1:0] occ_m = '0;
    exp_t sb_q[$];

    reserved_parking_exit_if #(.N(N)) bus ();

    reserved_parking_exit #(.N(N), .GATE_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [FW-1:0] free_of(input logic [NS-1:0] o);
        int c;
        c = 0;
        for (int k = 0; k < NS; k++) if (!o[k]) c++;
        return FW'(c);
    endfunction

    // Monitor: every exit_done pops one expectation.
    always @(negedge clk) begin
        if (rst_n && bus.exit_done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got err %0d with nothing expected", bus.err_code);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_err", 32'(bus.err_code), 32'(e.err));
                chk("done_occ", 32'(bus.occupancy), 32'(e.occ));
                chk("done_free", 32'(bus.free_count), 32'(e.fc));
            end
        end
    end

    task automatic entry(input int flat);
        @(negedge clk);
        bus.entry_set  = 1'b1;
        bus.entry_flat = FW'(flat);
        @(negedge clk);
        bus.entry_set  = 1'b0;
        if (flat >= 1 && flat <= NS) occ_m[flat-1] = 1'b1;
        chk("entry_occ", 32'(bus.occupancy), 32'(occ_m));
        chk("entry_free", 32'(bus.free_count), 32'(free_of(occ_m)));
    endtask

    // pass_at: gate-open cycle on which vehicle_passed is driven (0 = never).
    // set_flat: entry_set issued during the RELEASE cycle (0 = none).
    // poke: pulse exit_req while the gate is open.
    task automatic do_exit(input int flat, input bit pwd, input int pass_at, input int set_flat,
                           input bit poke, input logic [2:0] exp_err, input int exp_gate,
                           input int exp_lat);
        logic [NS-1:0] exp_occ;
        int  gate_cnt, k;
        bit  done, drop_pass;
        exp_occ = occ_m;
        if (exp_err == ERR_OK) exp_occ[flat-1] = 1'b0;
        if (set_flat >= 1 && set_flat <= NS) exp_occ[set_flat-1] = 1'b1;
        occ_m = exp_occ;
        sb_q.push_back('{err: exp_err, occ: exp_occ, fc: free_of(exp_occ)});
        issued++;
        @(negedge clk);
        bus.exit_req    = 1'b1;
        bus.pwd_flag    = pwd;
        bus.flat_number = FW'(flat);
        gate_cnt = 0; k = 0; done = 0; drop_pass = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
            bus.exit_req  = 1'b0;
            bus.entry_set = 1'b0;
            if (drop_pass) begin
                bus.vehicle_passed = 1'b0;
                drop_pass = 0;
                if (set_flat != 0) begin
                    bus.entry_set  = 1'b1;
                    bus.entry_flat = FW'(set_flat);
                end
            end
            if (bus.gate_open) begin
                gate_cnt++;
                if (gate_cnt == pass_at) begin
                    bus.vehicle_passed = 1'b1;
                    drop_pass = 1;
                end
                if (poke && gate_cnt == 2) bus.exit_req = 1'b1;
            end
            if (bus.exit_done) done = 1;
        end
        bus.vehicle_passed = 1'b0;
        bus.entry_set      = 1'b0;
        chk("exit_completed", 32'(done), 32'(1));
        chk("gate_cycles", 32'(gate_cnt), 32'(exp_gate));
        if (exp_lat > 0) chk("reject_latency", 32'(k), 32'(exp_lat));
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        bus.exit_req = 1'b0;
        bus.pwd_flag = 1'b0;
        bus.flat_number = '0;
        bus.vehicle_passed = 1'b0;
        bus.entry_set = 1'b0;
        bus.entry_flat = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_gate", 32'(bus.gate_open), 32'(0));
        chk("rst_done", 32'(bus.exit_done), 32'(0));
        chk("rst_err", 32'(bus.err_code), 32'(0));
        chk("rst_occ", 32'(bus.occupancy), 32'(0));
        chk("rst_free", 32'(bus.free_count), 32'(NS));
        rst_n = 1'b1;
        @(negedge clk);

        // Normal exit, pass on 5th gate cycle.
        entry(3);
        do_exit(3, 1'b1, 5, 0, 1'b0, ERR_OK, 5, 0);

        // Range rejects, including priority over a bad password.
        do_exit(0, 1'b1, 0, 0, 1'b0, ERR_INVALID, 0, 3);
        do_exit(N + 2, 1'b1, 0, 0, 1'b0, ERR_INVALID, 0, 3);
        do_exit(0, 1'b0, 0, 0, 1'b0, ERR_INVALID, 0, 3);
        entry(0);
        entry(N + 2);
        entry(NS);
        do_exit(NS, 1'b1, 2, 0, 1'b0, ERR_OK, 2, 0);

        // Auth and empty-slot rejects.
        entry(5);
        do_exit(5, 1'b0, 0, 0, 1'b0, ERR_AUTH, 0, 3);
        do_exit(6, 1'b1, 0, 0, 1'b0, ERR_EMPTY, 0, 3);

        // Timeout, then pass exactly on the timeout cycle.
        entry(2);
        do_exit(2, 1'b1, 0, 0, 1'b0, ERR_TIMEOUT, 16, 0);
        do_exit(2, 1'b1, 16, 0, 1'b0, ERR_OK, 16, 0);

        // Release colliding with entry on the same slot; exit_req while busy.
        entry(4);
        do_exit(4, 1'b1, 3, 4, 1'b1, ERR_OK, 3, 0);
        repeat (8) @(negedge clk);
        chk("no_extra_done", 32'(done_seen), 32'(issued));

        // Asynchronous reset during WAIT_PASS.
        entry(8);
        @(negedge clk);
        bus.exit_req = 1'b1;
        bus.pwd_flag = 1'b1;
        bus.flat_number = FW'(8);
        @(negedge clk);
        bus.exit_req = 1'b0;
        w = 0;
        while (!bus.gate_open && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("gate_before_reset", 32'(bus.gate_open), 32'(1));
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gate", 32'(bus.gate_open), 32'(0));
        chk("arst_busy", 32'(bus.busy), 32'(0));
        chk("arst_occ", 32'(bus.occupancy), 32'(0));
        chk("arst_free", 32'(bus.free_count), 32'(NS));
        occ_m = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        entry(8);
        do_exit(8, 1'b1, 3, 0, 1'b0, ERR_OK, 3, 0);

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'(0));
        chk("done_count", 32'(done_seen), 32'(issued));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
